alarm_bell: RTL and testbench

ALARM_BELL -- requirements
Module: alarm_bell

---
 rtl/alarm_bell.sv | 100 ++++++++++
 tb/tb_alarm_bell.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bell.sv
// alarm_bell: alarm-time editor, alarm ring FSM with blink, and hourly chime.
// Asynchronous inputs are synchronised and edge-detected in the clk domain.
module alarm_bell #(
  parameter int RING_SEC  = 60,
  parameter int CHIME_SEC = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        cp1hz,
  input  logic [23:0] time_bcd,
  input  logic        set,
  input  logic [3:0]  adj,
  input  logic        alm_en,
  input  logic        stop,
  output logic [15:0] alarm_bcd,
  output logic [2:0]  led
);
  typedef enum logic {IDLE, RING} state_t;

  state_t      r_state;
  logic [6:0]  r_s1, r_s2;
  logic [5:0]  r_d;
  logic [15:0] r_alarm;
  logic [7:0]  r_rcnt;
  logic        r_blink, r_led0;
  logic [3:0]  r_chime;

  logic [5:0]  w_pulse;
  logic        w_tick, w_stop_p, w_set, w_match;
  logic [3:0]  w_adj_p, w_m1, w_m10, w_h1, w_h10;
  logic [15:0] w_alarm_nx;

  // Bit order {set, stop, adj[3:0], cp1hz}; set needs no edge detector.
  assign w_pulse  = r_s2[5:0] & ~r_d;
  assign w_tick   = w_pulse[0];
  assign w_adj_p  = w_pulse[4:1];
  assign w_stop_p = w_pulse[5];
  assign w_set    = r_s2[6];
  assign {w_h10, w_h1, w_m10, w_m1} = r_alarm;
  assign w_match  = (time_bcd[23:8] == r_alarm) && (time_bcd[7:0] == 8'h00);

  always_comb begin
    w_alarm_nx = r_alarm;
    if (w_set) begin
      if (w_adj_p[0])
        w_alarm_nx[3:0] = (w_m1 == 4'd9) ? 4'd0 : w_m1 + 4'd1;
      else if (w_adj_p[1])
        w_alarm_nx[7:4] = (w_m10 == 4'd5) ? 4'd0 : w_m10 + 4'd1;
      else if (w_adj_p[2])
        w_alarm_nx[11:8] = (w_h1 == 4'd9 || (w_h10 == 4'd2 && w_h1 == 4'd3)) ? 4'd0 : w_h1 + 4'd1;
      else if (w_adj_p[3]) begin
        w_alarm_nx[15:12] = (w_h10 == 4'd2) ? 4'd0 : w_h10 + 4'd1;
        // Entering the 20s clamps h1 so the time stays at or below 23:59.
        if (w_h10 == 4'd1 && w_h1 > 4'd3) w_alarm_nx[11:8] = 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_d     <= '0;
      r_alarm <= '0;
      r_rcnt  <= '0;
      r_blink <= 1'b0;
      r_led0  <= 1'b0;
      r_chime <= '0;
    end else begin
      r_s1    <= {set, stop, adj, cp1hz};
      r_s2    <= r_s1;
      r_d     <= r_s2[5:0];
      r_alarm <= w_alarm_nx;
      if (r_state == IDLE) begin
        if (w_tick && alm_en && !w_set && w_match) begin
          r_state <= RING;
          r_rcnt  <= 8'(RING_SEC);
          r_blink <= 1'b1;
          r_led0  <= 1'b1;
        end
      end else if (w_stop_p || !alm_en || w_set || (w_tick && r_rcnt == 8'd1)) begin
        r_state <= IDLE;
        r_rcnt  <= '0;
        r_blink <= 1'b0;
        r_led0  <= 1'b0;
      end else if (w_tick) begin
        r_rcnt  <= r_rcnt - 8'd1;
        r_blink <= ~r_blink;
        r_led0  <= ~r_blink;
      end
      if (w_tick)
        r_chime <= (time_bcd[15:0] == 16'h0000) ? 4'(CHIME_SEC) :
                   (r_chime != 4'd0) ? r_chime - 4'd1 : 4'd0;
    end
  end

  assign alarm_bcd = r_alarm;
  assign led       = {w_set, r_chime != 4'd0, r_led0};
endmodule

// File: tb/tb_alarm_bell.sv
// tb_alarm_bell: directed and random checks of alarm_bell against a
// digit/seconds-level reference model of the alarm clock behaviour.
module tb_alarm_bell;
  logic        clk = 0, clr = 0, cp1hz = 0, set = 0, alm_en = 0, stop = 0;
  logic [23:0] time_bcd = '0;
  logic [3:0]  adj = '0;
  logic [15:0] alarm_bcd;
  logic [2:0]  led;

  int n_chk = 0, n_fail = 0;
  int ah = 0, am = 0, ring_left = 0, chime = 0;
  bit blink = 0, m_set = 0, m_en = 0;

  always #5 clk = ~clk;

  alarm_bell #(.RING_SEC(60), .CHIME_SEC(3)) dut (
    .clk(clk), .clr(clr), .cp1hz(cp1hz), .time_bcd(time_bcd), .set(set),
    .adj(adj), .alm_en(alm_en), .stop(stop), .alarm_bcd(alarm_bcd), .led(led)
  );

  function automatic logic [23:0] tbcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] exp_alarm();
    logic [23:0] t;
    t = tbcd(ah, am, 0);
    return t[23:8];
  endfunction

  function automatic logic [2:0] exp_led();
    return {m_set, chime != 0, (ring_left != 0) && blink};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " alarm"}, {8'h0, alarm_bcd}, {8'h0, exp_alarm()});
    chk({tag, " led"}, {21'h0, led}, {21'h0, exp_led()});
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int h, input int m, input int s);
    time_bcd = tbcd(h, m, s);
    cp1hz = 1;
    wait_clk(6);
    cp1hz = 0;
    wait_clk(6);
    if (ring_left != 0) begin
      if (ring_left == 1) ring_left = 0;
      else begin
        ring_left--;
        blink = ~blink;
      end
    end else if (m_en && !m_set && h == ah && m == am && s == 0) begin
      ring_left = 60;
      blink = 1;
    end
    chime = (m == 0 && s == 0) ? 3 : (chime > 0 ? chime - 1 : 0);
  endtask

  task automatic press(input logic [3:0] mask);
    int h10, h1, m10, m1;
    adj = mask;
    wait_clk(6);
    adj = 0;
    wait_clk(6);
    h10 = ah / 10; h1 = ah % 10; m10 = am / 10; m1 = am % 10;
    if (m_set) begin
      if (mask[0]) m1 = (m1 + 1) % 10;
      else if (mask[1]) m10 = (m10 + 1) % 6;
      else if (mask[2]) h1 = (h1 + 1) % (h10 == 2 ? 4 : 10);
      else if (mask[3]) begin
        h10 = (h10 + 1) % 3;
        if (h10 == 2 && h1 > 3) h1 = 3;
      end
    end
    ah = h10 * 10 + h1;
    am = m10 * 10 + m1;
  endtask

  task automatic set_mode(input bit v);
    set = v;
    wait_clk(4);
    m_set = v;
    if (v) ring_left = 0;
  endtask

  task automatic set_en(input bit v);
    alm_en = v;
    wait_clk(4);
    m_en = v;
    if (!v) ring_left = 0;
  endtask

  task automatic push_stop();
    stop = 1;
    wait_clk(4);
    ring_left = 0;
    chk_all("stop 4clk");
    stop = 0;
    wait_clk(6);
  endtask

  task automatic do_reset(input string tag);
    clr = 0;
    #1;
    ah = 0; am = 0; ring_left = 0; chime = 0; blink = 0;
    chk_all({tag, " during"});
    wait_clk(2);
    clr = 1;
    wait_clk(3);
    chk_all({tag, " after"});
  endtask

  initial begin
    wait_clk(3);
    chk_all("reset");
    clr = 1;
    wait_clk(3);

    set_mode(1);
    chk_all("set led2");
    repeat (2) press(4'b1000);
    repeat (3) press(4'b0100);
    chk("h1 wrap 23", {8'h0, alarm_bcd}, 24'h002300);
    repeat (4) press(4'b0100);
    chk("h1 wrap cycle", {8'h0, alarm_bcd}, 24'h002300);
    repeat (10) press(4'b0001);
    chk("m1 x10", {8'h0, alarm_bcd}, 24'h002300);

    press(4'b1000);
    repeat (6) press(4'b0100);
    chk("to 0900", {8'h0, alarm_bcd}, 24'h000900);
    repeat (2) press(4'b1000);
    chk("h10 clamp", {8'h0, alarm_bcd}, 24'h002300);

    press(4'b1000);
    repeat (3) press(4'b0100);
    repeat (3) press(4'b0010);
    chk("alarm 0630", {8'h0, alarm_bcd}, 24'h000630);
    set_mode(0);
    set_en(1);

    tick(6, 29, 59);
    chk_all("pre match");
    tick(6, 30, 0);
    chk("ring start", {23'h0, led[0]}, 24'h1);
    for (int k = 1; k <= 60; k++) begin
      tick(6, 30 + k / 60, k % 60);
      chk_all("ring blink");
    end
    chk("ring end", {23'h0, led[0]}, 24'h0);

    tick(6, 30, 0);
    tick(6, 30, 1);
    push_stop();
    for (int s = 2; s <= 5; s++) begin
      tick(6, 30, s);
      chk_all("no retrigger");
    end

    set_mode(1);
    repeat (3) press(4'b0010);
    press(4'b1000);
    repeat (7) press(4'b0100);
    chk("alarm 1300", {8'h0, alarm_bcd}, 24'h001300);
    set_mode(0);
    tick(12, 59, 59);
    chk_all("pre hour");
    tick(13, 0, 0);
    chk("alarm+chime", {22'h0, led[1:0]}, 24'h3);
    for (int s = 1; s <= 3; s++) begin
      tick(13, 0, s);
      chk_all("chime len");
    end

    do_reset("rst ring");
    tick(13, 0, 5);
    chk_all("no residual");
    tick(14, 0, 0);
    chk("chime on", {23'h0, led[1]}, 24'h1);
    do_reset("rst chime");
    tick(14, 0, 1);
    chk_all("chime cleared");

    for (int i = 0; i < 300; i++) begin
      int r, c;
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 2);
      if (r <= 3 || r == 9) begin
        if (r == 9 || c == 0) tick(ah, am, 0);
        else if (c == 1) tick($urandom_range(0, 23), 0, 0);
        else tick($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end else if (r <= 5) press(4'($urandom_range(1, 15)));
      else if (r == 6) set_mode(~m_set);
      else if (r == 7) push_stop();
      else set_en($urandom_range(0, 3) != 0);
      chk_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
